// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : ctrl_pkg
//  Description: Shared opcodes, ALU-operation encoding, forwarding selects
//               and the per-instruction control bundle for pipe_controller.
//  Revision   : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  // RV32 major opcodes recognised by the decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU second-operand source
  localparam logic [1:0] SRC_RS2 = 2'b00;
  localparam logic [1:0] SRC_PC  = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  // ALU operation class handed to the EX stage
  typedef enum logic [3:0] {
    ALU_REG    = 4'd0,
    ALU_IMM    = 4'd1,
    ALU_ADDR   = 4'd2,
    ALU_BRANCH = 4'd3,
    ALU_LINK   = 4'd4,
    ALU_LUI    = 4'd5
  } alu_op_t;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } fwd_sel_t;

  // Control bundle produced by decode and carried into EX
  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic [1:0] ALUSrc;
    alu_op_t    ALUOp;
    logic       uses_rs1;
    logic       uses_rs2;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module     : ctrl_decode
//  Description: Purely combinational opcode decoder. Produces the control
//               bundle for the ID instruction and flags unsupported opcodes.
//  Revision   : 1.0  initial release
// ============================================================================
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal
);

  // Only the opcode field drives control; the rest of the word is decoded
  // downstream by the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31:7];

  // Opcode table; anything unlisted is illegal and yields an all-zero bundle
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (inst[6:0])
      OP_R: begin
        ctrl.ALUOp    = ALU_REG;
        ctrl.RegWrite = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        ctrl.ALUOp    = ALU_IMM;
        ctrl.ALUSrc   = SRC_IMM;
        ctrl.RegWrite = 1'b1;
        ctrl.uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.ALUOp    = ALU_ADDR;
        ctrl.ALUSrc   = SRC_IMM;
        ctrl.MemRead  = 1'b1;
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.ALUOp    = ALU_ADDR;
        ctrl.ALUSrc   = SRC_IMM;
        ctrl.MemWrite = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.ALUOp    = ALU_BRANCH;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.ALUOp    = ALU_LINK;
        ctrl.ALUSrc   = SRC_PC;
        ctrl.RegWrite = 1'b1;
      end
      OP_JALR: begin
        ctrl.ALUOp    = ALU_LINK;
        ctrl.ALUSrc   = SRC_PC;
        ctrl.RegWrite = 1'b1;
        ctrl.uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        ctrl.ALUOp    = ALU_LUI;
        ctrl.RegWrite = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.ALUOp    = ALU_IMM;
        ctrl.ALUSrc   = SRC_PC;
        ctrl.RegWrite = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
//  Module     : pipe_controller
//  Description: Pipelined control unit. Decodes ID, carries control through
//               EX/MEM/WB, detects load-use and RAW hazards, selects operand
//               forwarding and squashes the wrong path on an EX redirect.
//  Revision   : 1.0  initial release
// ============================================================================
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_inst,
  input  logic               ex_redirect,
  output logic               stall,
  output logic               flush,
  output logic               id_illegal,
  output logic               ex_valid,
  output logic [1:0]         ex_ALUSrc,
  output logic [3:0]         ex_ALUOp,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_valid,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               wb_valid,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [RADDR_W-1:0] wb_rd
);

  // A producer matches a consumer source when it is live, writes the
  // register file, and targets the same non-zero register.
  function automatic logic hit(input logic vld, input logic rw,
                               input logic [RADDR_W-1:0] rd,
                               input logic [RADDR_W-1:0] rs);
    return vld && rw && (rd != '0) && (rd == rs);
  endfunction

  // ---------------------------------------------------------------- ID ----
  ctrl_t              id_ctrl;
  logic               id_bad;
  logic               id_live;
  logic [RADDR_W-1:0] id_rd;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;

  ctrl_decode u_decode (
    .inst    (id_inst),
    .ctrl    (id_ctrl),
    .illegal (id_bad)
  );

  assign id_rd   = id_inst[7  +: RADDR_W];
  assign id_rs1  = id_inst[15 +: RADDR_W];
  assign id_rs2  = id_inst[20 +: RADDR_W];
  assign id_live = id_valid && !id_bad;

  // ------------------------------------------------------ stage state ----
  logic               ex_vld;
  ctrl_t              ex_ctl;
  logic [RADDR_W-1:0] ex_rd;
  logic [RADDR_W-1:0] ex_rs1;
  logic [RADDR_W-1:0] ex_rs2;

  logic               mem_vld;
  logic               mem_rw;
  logic               mem_mr;
  logic               mem_mw;
  logic               mem_m2r;
  logic [RADDR_W-1:0] mem_dst;

  logic               wb_vld;
  logic               wb_rw;
  logic               wb_m2r;
  logic [RADDR_W-1:0] wb_dst;

  // ---------------------------------------------------------- hazards ----
  logic id_dep_ex;
  logic raw_stall;
  logic ex_load;

  assign id_dep_ex = id_live &&
                     ((id_ctrl.uses_rs1 && hit(ex_vld, ex_ctl.RegWrite, ex_rd, id_rs1)) ||
                      (id_ctrl.uses_rs2 && hit(ex_vld, ex_ctl.RegWrite, ex_rd, id_rs2)));

  generate
    if (FWD_EN) begin : g_fwd
      fwd_sel_t sel_a;
      fwd_sel_t sel_b;

      // Only a load in EX cannot be forwarded in time
      assign raw_stall = id_dep_ex && ex_ctl.MemRead;

      // Youngest producer wins: MEM before WB
      always_comb begin
        sel_a = FWD_REGFILE;
        sel_b = FWD_REGFILE;
        if (ex_vld && ex_ctl.uses_rs1) begin
          if (hit(mem_vld, mem_rw, mem_dst, ex_rs1))     sel_a = FWD_MEM;
          else if (hit(wb_vld, wb_rw, wb_dst, ex_rs1))   sel_a = FWD_WB;
        end
        if (ex_vld && ex_ctl.uses_rs2) begin
          if (hit(mem_vld, mem_rw, mem_dst, ex_rs2))     sel_b = FWD_MEM;
          else if (hit(wb_vld, wb_rw, wb_dst, ex_rs2))   sel_b = FWD_WB;
        end
      end

      assign fwd_a = sel_a;
      assign fwd_b = sel_b;
    end else begin : g_no_fwd
      logic id_dep_mem;
      logic unused_fwd_regs;

      // Without bypass paths, wait until the producer has reached WB; the
      // write-through register file covers the WB case.
      assign id_dep_mem = id_live &&
                          ((id_ctrl.uses_rs1 && hit(mem_vld, mem_rw, mem_dst, id_rs1)) ||
                           (id_ctrl.uses_rs2 && hit(mem_vld, mem_rw, mem_dst, id_rs2)));
      assign raw_stall  = id_dep_ex || id_dep_mem;

      assign fwd_a = FWD_REGFILE;
      assign fwd_b = FWD_REGFILE;

      assign unused_fwd_regs = ^{ex_rs1, ex_rs2, ex_ctl.uses_rs1, ex_ctl.uses_rs2};
    end
  endgenerate

  // A redirect always wins: the ID instruction is on the wrong path anyway
  assign stall      = raw_stall && !ex_redirect;
  assign flush      = ex_redirect;
  assign id_illegal = id_valid && id_bad;
  assign ex_load    = id_live && !raw_stall && !ex_redirect;

  // Pipeline registers; EX takes a bubble whenever ID does not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld  <= 1'b0;
      ex_ctl  <= '0;
      ex_rd   <= '0;
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      mem_vld <= 1'b0;
      mem_rw  <= 1'b0;
      mem_mr  <= 1'b0;
      mem_mw  <= 1'b0;
      mem_m2r <= 1'b0;
      mem_dst <= '0;
      wb_vld  <= 1'b0;
      wb_rw   <= 1'b0;
      wb_m2r  <= 1'b0;
      wb_dst  <= '0;
    end else begin
      if (ex_load) begin
        ex_vld <= 1'b1;
        ex_ctl <= id_ctrl;
        ex_rd  <= id_rd;
        ex_rs1 <= id_rs1;
        ex_rs2 <= id_rs2;
      end else begin
        ex_vld <= 1'b0;
        ex_ctl <= '0;
        ex_rd  <= '0;
        ex_rs1 <= '0;
        ex_rs2 <= '0;
      end
      mem_vld <= ex_vld;
      mem_rw  <= ex_ctl.RegWrite;
      mem_mr  <= ex_ctl.MemRead;
      mem_mw  <= ex_ctl.MemWrite;
      mem_m2r <= ex_ctl.MemtoReg;
      mem_dst <= ex_rd;
      wb_vld  <= mem_vld;
      wb_rw   <= mem_rw;
      wb_m2r  <= mem_m2r;
      wb_dst  <= mem_dst;
    end
  end

  // ---------------------------------------------------------- outputs ----
  assign ex_valid     = ex_vld;
  assign ex_ALUSrc    = ex_vld ? ex_ctl.ALUSrc : 2'b00;
  assign ex_ALUOp     = ex_vld ? ex_ctl.ALUOp  : 4'd0;
  assign mem_valid    = mem_vld;
  assign mem_MemRead  = mem_vld && mem_mr;
  assign mem_MemWrite = mem_vld && mem_mw;
  assign wb_valid     = wb_vld;
  assign wb_RegWrite  = wb_vld && wb_rw;
  assign wb_MemtoReg  = wb_vld && wb_m2r;
  assign wb_rd        = wb_vld ? wb_dst : '0;

endmodule
`default_nettype wire
